svc_rv_stall_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RV pipeline. It merges four stall and flush sources into one per-stage control vector with fixed priority: data-memory wait, multi-cycle EX unit, control redirect, and the combinational data-hazard stall. It also sequences the multi-cycle EX unit (mul/div) start/done handshake. It sits beside the hazard unit and drives the enables and bubble-inserts of every pipeline register.

---
 rtl/svc_rv_stall_ctrl.sv | 115 +++++++++++
 tb/tb_svc_rv_stall_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_stall_ctrl.sv
// Central stall/flush scheduler: merges mem-wait, multi-cycle EX, redirect and hazard stalls.
// Optional performance counters are built when SVC_RV_PERF_EN is defined. dbg_state: 0 RUN, 1 MC_BUSY, 2 MC_DONE_WAIT.
module svc_rv_stall_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hazard_stall,
  input  logic                 redirect,
  input  logic                 mc_req,
  input  logic                 mc_done,
  input  logic                 dmem_busy,
  output logic                 mc_start,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_ex_stall,
  output logic                 ex_mem_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_flush,
`ifdef SVC_RV_PERF_EN
  output logic [CNT_WIDTH-1:0] stall_mem_cnt,
  output logic [CNT_WIDTH-1:0] stall_mc_cnt,
  output logic [CNT_WIDTH-1:0] stall_hz_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    MC_BUSY      = 2'd1,
    MC_DONE_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic win_mem, win_mc, win_rd, win_hz;

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    mc_start  = 1'b0;
    case (state)
      RUN: begin
        if (mc_req && !dmem_busy) begin
          mc_start  = 1'b1;
          state_nxt = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (mc_done) state_nxt = dmem_busy ? MC_DONE_WAIT : RUN;
      end
      MC_DONE_WAIT: begin
        if (!dmem_busy) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Exactly one priority level wins per cycle; redirect is only honoured while EX is free (RUN).
  always_comb begin
    win_mem = 1'b0;
    win_mc  = 1'b0;
    win_rd  = 1'b0;
    win_hz  = 1'b0;
    if (dmem_busy)
      win_mem = 1'b1;
    else if ((state == MC_BUSY && !mc_done) || (state == RUN && mc_req))
      win_mc = 1'b1;
    else if (redirect && state == RUN)
      win_rd = 1'b1;
    else if (hazard_stall)
      win_hz = 1'b1;
  end

  always_comb begin
    pc_stall     = win_mem | win_mc | win_hz;
    if_id_stall  = win_mem | win_mc | win_hz;
    id_ex_stall  = win_mem | win_mc;
    ex_mem_stall = win_mem;
    if_id_flush  = win_rd;
    id_ex_flush  = win_rd | win_hz;
    ex_mem_flush = win_mc;
    mem_wb_flush = win_mem;
  end

`ifdef SVC_RV_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_mem_cnt <= '0;
      stall_mc_cnt  <= '0;
      stall_hz_cnt  <= '0;
      flush_cnt     <= '0;
    end else begin
      if (win_mem) stall_mem_cnt <= stall_mem_cnt + 1'b1;
      if (win_mc)  stall_mc_cnt  <= stall_mc_cnt + 1'b1;
      if (win_hz)  stall_hz_cnt  <= stall_hz_cnt + 1'b1;
      if (win_rd)  flush_cnt     <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_svc_rv_stall_ctrl.sv
// Bench for svc_rv_stall_ctrl: directed scenarios plus random traffic against a priority-rule model.
// Counter checks are compiled in when SVC_RV_PERF_EN is defined.
module tb_svc_rv_stall_ctrl;

  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_HOLD = 2;

  logic clk = 1'b0;
  logic rst_n, hazard_stall, redirect, mc_req, mc_done, dmem_busy;
  logic mc_start, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] dbg_state;
`ifdef SVC_RV_PERF_EN
  logic [31:0] stall_mem_cnt, stall_mc_cnt, stall_hz_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  int phase;
  int unsigned m_mem, m_mc, m_hz, m_fl;

  svc_rv_stall_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .hazard_stall(hazard_stall), .redirect(redirect),
    .mc_req(mc_req), .mc_done(mc_done), .dmem_busy(dmem_busy),
    .mc_start(mc_start),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
`ifdef SVC_RV_PERF_EN
    .stall_mem_cnt(stall_mem_cnt), .stall_mc_cnt(stall_mc_cnt),
    .stall_hz_cnt(stall_hz_cnt), .flush_cnt(flush_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winning priority: 1 mem wait, 2 mc stall, 3 redirect, 4 hazard, 0 none.
  function automatic int win_level(input logic hz, rd, mr, md, db);
    if (db) return 1;
    if ((phase == PH_BUSY && !md) || (phase == PH_IDLE && mr)) return 2;
    if (rd && phase == PH_IDLE) return 3;
    if (hz) return 4;
    return 0;
  endfunction

  // Expected {mc_start, 4 stalls (pc..ex_mem), 4 flushes (if_id..mem_wb)}
  function automatic logic [8:0] expect_vec(input int lvl, input logic start);
    logic [8:0] v;
    case (lvl)
      1:       v = 9'b0_1111_0001;
      2:       v = 9'b0_1110_0010;
      3:       v = 9'b0_0000_1100;
      4:       v = 9'b0_1100_0100;
      default: v = 9'b0_0000_0000;
    endcase
    v[8] = start;
    return v;
  endfunction

  // driver: apply one cycle of inputs, check mid-cycle, then advance the model past the edge
  task automatic step(input logic rn, hz, rd, mr, md, db);
    int lvl;
    int nxt;
    logic start;
    rst_n = rn; hazard_stall = hz; redirect = rd;
    mc_req = mr; mc_done = md; dmem_busy = db;
    @(negedge clk);
    lvl   = win_level(hz, rd, mr, md, db);
    start = (phase == PH_IDLE) && mr && !db;
    exp_q.push_back(expect_vec(lvl, start));
    check("ctl", {mc_start, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, exp_q.pop_front());
    check("state", dbg_state, phase);
    nxt = phase;
    if (!rn) nxt = PH_IDLE;
    else if (phase == PH_IDLE && start) nxt = PH_BUSY;
    else if (phase == PH_BUSY && md) nxt = db ? PH_HOLD : PH_IDLE;
    else if (phase == PH_HOLD && !db) nxt = PH_IDLE;
    if (!rn) begin
      m_mem = 0; m_mc = 0; m_hz = 0; m_fl = 0;
    end else begin
      if (lvl == 1) m_mem++;
      if (lvl == 2) m_mc++;
      if (lvl == 3) m_fl++;
      if (lvl == 4) m_hz++;
    end
    @(posedge clk);
    #1;
    phase = nxt;
`ifdef SVC_RV_PERF_EN
    check("cnt_mem", stall_mem_cnt, m_mem);
    check("cnt_mc", stall_mc_cnt, m_mc);
    check("cnt_hz", stall_hz_cnt, m_hz);
    check("cnt_flush", flush_cnt, m_fl);
`endif
  endtask

  function automatic logic pick(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  initial begin
    rst_n = 1'b0; hazard_stall = 1'b0; redirect = 1'b0;
    mc_req = 1'b0; mc_done = 1'b0; dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    phase = PH_IDLE;
    m_mem = 0; m_mc = 0; m_hz = 0; m_fl = 0;

    // reset with idle inputs, then a lone hazard
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    // four-cycle mul/div, then a back-to-back op
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    check("mc_back_to_back_state", dbg_state, PH_IDLE);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);

    // redirect beats hazard
    step(1, 1, 1, 0, 0, 0);

    // mem wait hides redirect until it clears
    repeat (3) step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);

    // done while memory is busy parks in MC_DONE_WAIT
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1);
    check("done_wait_state", dbg_state, PH_HOLD);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    check("done_wait_exit", dbg_state, PH_IDLE);

    // mc_done in RUN is ignored; reset aborts MC_BUSY
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("reset_from_busy", dbg_state, PH_IDLE);

    // counter scenario: 3 mem waits, 2 mc stalls, 1 redirect
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
`ifdef SVC_RV_PERF_EN
    check("perf_mem_3", stall_mem_cnt, 3);
    check("perf_mc_2", stall_mc_cnt, 2);
    check("perf_flush_1", flush_cnt, 1);
    check("perf_hz_0", stall_hz_cnt, 0);
    step(0, 0, 0, 0, 0, 0);
    check("perf_rst_mem", stall_mem_cnt, 0);
    check("perf_rst_mc", stall_mc_cnt, 0);
    check("perf_rst_flush", flush_cnt, 0);
`endif

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(pick(98), pick(25), pick(20),
           (phase == PH_IDLE) ? pick(30) : pick(90),
           pick(30), pick(25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
